// File: rtl/irrigation_pkg.sv
// Shared types and constants for the multi-zone irrigation controller.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATER    = 2'd1,
        COOLDOWN = 2'd2
    } zone_state_t;

    localparam logic [1:0] LVL_EMPTY = 2'b00;
    localparam logic [1:0] LVL_LOW   = 2'b01;
    localparam logic [1:0] LVL_OK    = 2'b10;
    localparam logic [1:0] LVL_FULL  = 2'b11;

endpackage

// File: rtl/irrigation_ctrl_if.sv
// Sensor inputs and actuator outputs of the irrigation controller.
interface irrigation_ctrl_if #(
    parameter int unsigned NZONES = 4,
    parameter int unsigned MW     = 8
);
    localparam int unsigned ZW = $clog2(NZONES);

    logic [NZONES*MW-1:0] Moisture_sensor;
    logic [1:0]           Water_sensor;
    logic                 Fault_clr;
    logic                 Pump;
    logic [NZONES-1:0]    Sprinkler;
    logic [ZW-1:0]        Active_zone;
    logic [NZONES-1:0]    Fault;

    // Environment / supervisor side: drives sensors, observes actuators.
    modport master (
        output Moisture_sensor, Water_sensor, Fault_clr,
        input  Pump, Sprinkler, Active_zone, Fault
    );

    // Controller side.
    modport slave (
        input  Moisture_sensor, Water_sensor, Fault_clr,
        output Pump, Sprinkler, Active_zone, Fault
    );
endinterface

// File: rtl/irrigation_ctrl_tank_pump_ctrl.sv
// Tank-fill pump with level hysteresis: on at empty/low, off at full.
module tank_pump_ctrl
    import irrigation_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [1:0] Water_sensor,
    output logic       Pump
);

    // Pump register: set below OK, cleared at FULL, held at OK.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Pump <= 1'b0;
        end else begin
            case (Water_sensor)
                LVL_EMPTY, LVL_LOW: Pump <= 1'b1;
                LVL_FULL:           Pump <= 1'b0;
                default:            Pump <= Pump;
            endcase
        end
    end

endmodule

// File: rtl/irrigation_ctrl.sv
// Multi-zone irrigation controller: round-robin zone watering with
// hysteresis, max-on timeout with sticky per-zone fault, and cooldown.
module irrigation_ctrl
    import irrigation_pkg::*;
#(
    parameter int unsigned NZONES  = 4,
    parameter int unsigned MW      = 8,
    parameter int unsigned LOW_TH  = 64,
    parameter int unsigned HIGH_TH = 160,
    parameter int unsigned MAX_ON  = 16,
    parameter int unsigned COOL    = 4
)(
    input  logic              CLK,
    input  logic              Reset,
    irrigation_ctrl_if.slave  bus
);

    localparam int unsigned ZW = $clog2(NZONES);
    localparam int unsigned TW = $clog2(MAX_ON + 1);
    localparam int unsigned CW = $clog2(COOL + 1);

    localparam logic [MW-1:0] LOW_V  = MW'(LOW_TH);
    localparam logic [MW-1:0] HIGH_V = MW'(HIGH_TH);

    zone_state_t       state, state_n;
    logic [ZW-1:0]     ptr, ptr_n;
    logic [TW-1:0]     timer, timer_n;
    logic [CW-1:0]     cool, cool_n;
    logic [NZONES-1:0] sprk, sprk_n;
    logic [ZW-1:0]     az, az_n;
    logic [NZONES-1:0] fault, fault_n;

    logic [NZONES-1:0] dry;
    logic [ZW:0]       pick;
    logic [MW-1:0]     cur_moist;
    logic              cur_wet;
    logic              tank_empty;

    // First set bit of elig at or after start, wrapping; MSB flags a hit.
    function automatic logic [ZW:0] pick_zone(input logic [NZONES-1:0] elig,
                                              input logic [ZW-1:0]     start);
        logic [ZW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned i = 0; i < NZONES; i++) begin
            idx = int'(start) + i;
            if (idx >= NZONES) idx = idx - NZONES;
            if (elig[idx] && !res[ZW]) res = {1'b1, ZW'(idx)};
        end
        return res;
    endfunction

    // Per-zone dry flags from the packed moisture bus.
    always_comb begin
        dry = '0;
        for (int unsigned z = 0; z < NZONES; z++) begin
            dry[z] = bus.Moisture_sensor[z*MW +: MW] < LOW_V;
        end
    end

    assign pick       = pick_zone(dry & ~fault, ptr);
    assign cur_moist  = bus.Moisture_sensor[az*MW +: MW];
    assign cur_wet    = cur_moist >= HIGH_V;
    assign tank_empty = bus.Water_sensor == LVL_EMPTY;

    // Zone FSM next-state and registered-output next values.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        timer_n = timer;
        cool_n  = cool;
        sprk_n  = sprk;
        az_n    = az;
        fault_n = fault;

        case (state)
            IDLE: begin
                sprk_n = '0;
                if (!tank_empty && pick[ZW]) begin
                    state_n = WATER;
                    az_n    = pick[ZW-1:0];
                    sprk_n  = NZONES'(1) << pick[ZW-1:0];
                    timer_n = TW'(1);
                end
            end
            WATER: begin
                if (cur_wet || tank_empty || timer == TW'(MAX_ON)) begin
                    state_n = COOLDOWN;
                    sprk_n  = '0;
                    timer_n = '0;
                    cool_n  = CW'(1);
                    ptr_n   = (az == ZW'(NZONES - 1)) ? '0 : az + 1'b1;
                    // Wet and empty-tank exits take priority over the timeout fault.
                    if (!cur_wet && !tank_empty) fault_n[az] = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            COOLDOWN: begin
                sprk_n = '0;
                if (cool == CW'(COOL)) begin
                    state_n = IDLE;
                    cool_n  = '0;
                end else begin
                    cool_n = cool + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                sprk_n  = '0;
            end
        endcase

        // Clear overrides a timeout fault raised on the same edge.
        if (bus.Fault_clr) fault_n = '0;
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= '0;
            timer <= '0;
            cool  <= '0;
            sprk  <= '0;
            az    <= '0;
            fault <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            timer <= timer_n;
            cool  <= cool_n;
            sprk  <= sprk_n;
            az    <= az_n;
            fault <= fault_n;
        end
    end

    assign bus.Sprinkler   = sprk;
    assign bus.Active_zone = az;
    assign bus.Fault       = fault;

    tank_pump_ctrl u_pump (
        .CLK          (CLK),
        .Reset        (Reset),
        .Water_sensor (bus.Water_sensor),
        .Pump         (bus.Pump)
    );

endmodule

// File: tb/tb_irrigation_ctrl.sv
// Directed bench for irrigation_ctrl (NZONES=4, MW=8, LOW=64, HIGH=160,
// MAX_ON=16, COOL=4).
module tb_irrigation_ctrl;
    import irrigation_pkg::*;

    localparam logic [7:0] D = 8'd32;
    localparam logic [7:0] H = 8'd200;
    localparam logic [7:0] M = 8'd170;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irrigation_ctrl_if #(.NZONES(4), .MW(8)) bus ();

    irrigation_ctrl #(
        .NZONES(4), .MW(8), .LOW_TH(64), .HIGH_TH(160), .MAX_ON(16), .COOL(4)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] m;
        logic [1:0]  w;
        logic        pump;
        logic [3:0]  sp;
        logic [1:0]  az;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [31:0] mz(input logic [7:0] z3, input logic [7:0] z2,
                                       input logic [7:0] z1, input logic [7:0] z0);
        return {z3, z2, z1, z0};
    endfunction

    task automatic drive(input logic [31:0] m, input logic [1:0] w,
                         input logic clr, input logic r);
        @(negedge clk);
        bus.Moisture_sensor = m;
        bus.Water_sensor    = w;
        bus.Fault_clr       = clr;
        rst                 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input logic [3:0] sp, input logic [1:0] az,
                        input logic [3:0] f);
        chk({nm, ".sprinkler"}, 32'(bus.Sprinkler), 32'(sp));
        chk({nm, ".zone"}, 32'(bus.Active_zone), 32'(az));
        chk({nm, ".fault"}, 32'(bus.Fault), 32'(f));
    endtask

    // Apply n identical cycles, checking zone outputs after each.
    task automatic hold(input string nm, input int unsigned n, input logic [31:0] m,
                        input logic [3:0] sp, input logic [1:0] az, input logic [3:0] f);
        for (int unsigned i = 0; i < n; i++) begin
            drive(m, LVL_OK, 1'b0, 1'b0);
            chk3(nm, sp, az, f);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Moisture_sensor = '0;
        bus.Water_sensor    = LVL_OK;
        bus.Fault_clr       = 1'b0;

        tbl[0]  = '{mz(H,H,H,H), LVL_OK,    1'b0, 4'b0000, 2'd0, 4'b0000};
        tbl[1]  = '{mz(H,D,H,H), LVL_OK,    1'b0, 4'b0100, 2'd2, 4'b0000};
        tbl[2]  = '{mz(H,D,H,H), LVL_LOW,   1'b1, 4'b0100, 2'd2, 4'b0000};
        tbl[3]  = '{mz(H,M,H,H), LVL_OK,    1'b1, 4'b0000, 2'd2, 4'b0000};
        tbl[4]  = '{mz(H,M,H,D), LVL_FULL,  1'b0, 4'b0000, 2'd2, 4'b0000};
        tbl[5]  = '{mz(H,M,H,D), LVL_OK,    1'b0, 4'b0000, 2'd2, 4'b0000};
        tbl[6]  = '{mz(H,M,H,D), LVL_OK,    1'b0, 4'b0000, 2'd2, 4'b0000};
        tbl[7]  = '{mz(H,M,H,D), LVL_OK,    1'b0, 4'b0000, 2'd2, 4'b0000};
        tbl[8]  = '{mz(H,M,H,D), LVL_OK,    1'b0, 4'b0001, 2'd0, 4'b0000};
        tbl[9]  = '{mz(H,M,H,D), LVL_EMPTY, 1'b1, 4'b0000, 2'd0, 4'b0000};
        tbl[10] = '{mz(H,H,H,H), LVL_FULL,  1'b0, 4'b0000, 2'd0, 4'b0000};
        tbl[11] = '{mz(H,H,H,H), LVL_FULL,  1'b0, 4'b0000, 2'd0, 4'b0000};
        tbl[12] = '{mz(H,H,H,H), LVL_FULL,  1'b0, 4'b0000, 2'd0, 4'b0000};
        tbl[13] = '{mz(H,H,H,H), LVL_FULL,  1'b0, 4'b0000, 2'd0, 4'b0000};
        tbl[14] = '{mz(H,H,D,H), LVL_EMPTY, 1'b1, 4'b0000, 2'd0, 4'b0000};
        tbl[15] = '{mz(H,H,D,H), LVL_EMPTY, 1'b1, 4'b0000, 2'd0, 4'b0000};
        tbl[16] = '{mz(H,H,H,H), LVL_OK,    1'b1, 4'b0000, 2'd0, 4'b0000};
        tbl[17] = '{mz(H,H,H,H), LVL_FULL,  1'b0, 4'b0000, 2'd0, 4'b0000};

        // Reset held for two edges with random inputs.
        for (int i = 0; i < 2; i++) begin
            drive($urandom, 2'($urandom_range(3)), 1'($urandom_range(1)), 1'b1);
        end
        chk("reset.pump", 32'(bus.Pump), 32'd0);
        chk3("reset", 4'b0000, 2'd0, 4'b0000);

        // Single zone, cooldown length, abort on empty tank, pump hysteresis.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].m, tbl[i].w, 1'b0, 1'b0);
            chk($sformatf("vec%0d.pump", i), 32'(bus.Pump), 32'(tbl[i].pump));
            chk3($sformatf("vec%0d", i), tbl[i].sp, tbl[i].az, tbl[i].f);
        end

        // Timeout on zone3: 16 cycles high, then sticky fault until cleared.
        hold("to3.on", 16, mz(D,H,H,H), 4'b1000, 2'd3, 4'b0000);
        hold("to3.trip", 1, mz(D,H,H,H), 4'b0000, 2'd3, 4'b1000);
        hold("to3.skip", 10, mz(D,H,H,H), 4'b0000, 2'd3, 4'b1000);
        drive(mz(D,H,H,H), LVL_OK, 1'b1, 1'b0);
        chk3("to3.clr", 4'b0000, 2'd3, 4'b0000);
        hold("to3.again", 1, mz(D,H,H,H), 4'b1000, 2'd3, 4'b0000);
        hold("to3.wet", 5, mz(H,H,H,H), 4'b0000, 2'd3, 4'b0000);

        // Round-robin: zone0 times out, then zone1 (not zone0) is chosen.
        hold("rr0.on", 16, mz(H,H,D,D), 4'b0001, 2'd0, 4'b0000);
        hold("rr0.trip", 1, mz(H,H,D,D), 4'b0000, 2'd0, 4'b0001);
        hold("rr0.cool", 4, mz(H,H,D,D), 4'b0000, 2'd0, 4'b0001);
        hold("rr1.on", 16, mz(H,H,D,D), 4'b0010, 2'd1, 4'b0001);
        hold("rr1.trip", 1, mz(H,H,D,D), 4'b0000, 2'd1, 4'b0011);
        hold("rr1.cool", 5, mz(H,H,D,D), 4'b0000, 2'd1, 4'b0011);

        // Clear coinciding with a timeout: clear wins.
        drive(mz(H,H,D,D), LVL_OK, 1'b1, 1'b0);
        chk3("clr.idle", 4'b0000, 2'd1, 4'b0000);
        hold("clr.on", 16, mz(H,H,D,D), 4'b0001, 2'd0, 4'b0000);
        drive(mz(H,H,D,D), LVL_OK, 1'b1, 1'b0);
        chk3("clr.trip", 4'b0000, 2'd0, 4'b0000);
        hold("clr.cool", 4, mz(H,H,D,D), 4'b0000, 2'd0, 4'b0000);

        // Wet on the timeout edge: normal finish, no fault.
        hold("wet.on", 16, mz(H,H,D,D), 4'b0010, 2'd1, 4'b0000);
        hold("wet.edge", 1, mz(H,H,H,D), 4'b0000, 2'd1, 4'b0000);
        hold("wet.cool", 4, mz(H,D,H,D), 4'b0000, 2'd1, 4'b0000);

        // Reset at timer=7: restart from zone0 with a full budget.
        hold("rst.on", 7, mz(H,D,H,D), 4'b0100, 2'd2, 4'b0000);
        drive(mz(H,D,H,D), LVL_OK, 1'b0, 1'b1);
        chk("rst.pump", 32'(bus.Pump), 32'd0);
        chk3("rst.mid", 4'b0000, 2'd0, 4'b0000);
        hold("rst.re", 16, mz(H,D,H,D), 4'b0001, 2'd0, 4'b0000);
        hold("rst.trip", 1, mz(H,D,H,D), 4'b0000, 2'd0, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irrigation_ctrl.md
Name: irrigation_ctrl

Overview:
- Multi-zone successor to the single-zone water controller.
- Reads NZONES packed moisture readings and one 2-bit tank-level sensor. Drives a tank-fill Pump and one Sprinkler valve per zone.
- Waters one zone at a time, round-robin, with hysteresis, a max-on timeout with sticky per-zone fault, and a post-watering cooldown.
- Top-level controller; outputs go directly to actuator drivers.

Parameters:
- NZONES, 4, number of irrigation zones (>=2).
- MW, 8, moisture reading width per zone (unsigned).
- LOW_TH, 64, zone is "dry" when moisture < LOW_TH.
- HIGH_TH, 160, zone is "wet" when moisture >= HIGH_TH; requires HIGH_TH > LOW_TH.
- MAX_ON, 16, maximum consecutive cycles a Sprinkler may be high.
- COOL, 4, cooldown cycles after any watering episode.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Moisture_sensor  in  NZONES*MW  zone z occupies bits [z*MW +: MW].
- Water_sensor  in  2  tank level: 00 empty, 01 low, 10 ok, 11 full.
- Fault_clr  in  1  single-cycle pulse; clears all Fault bits.
- Pump  out  1  tank-fill pump enable.
- Sprinkler  out  NZONES  one-hot valve enables, or all zero.
- Active_zone  out  clog2(NZONES)  zone being watered; holds the last value otherwise.
- Fault  out  NZONES  sticky per-zone timeout flags.

Behaviour:
- Reset: synchronous, active-high, one clock; Reset=1 at an edge wins over every other input.
  - Outputs after the reset edge: Pump=0, Sprinkler=0, Active_zone=0, Fault=0.
  - Internal state after the reset edge: FSM=IDLE, round-robin pointer=0, timers=0.
- All outputs are registered. Inputs are sampled at each rising edge and the response appears after that same edge.
- Pump (hysteresis):
  - Turns on at an edge where Water_sensor <= 01.
  - Turns off at an edge where Water_sensor == 11.
  - Holds its value for 10.
  - Independent of the zone FSM.
- Zone FSM states: IDLE, WATER, COOLDOWN.
- IDLE:
  - A zone is eligible if it is dry AND its Fault bit is 0.
  - If Water_sensor != 00 and any zone is eligible, pick the first eligible zone searching from the pointer upward, with wrap.
  - At that edge: go to WATER, set Sprinkler[z]=1, Active_zone=z, timer=1.
  - Otherwise stay in IDLE with Sprinkler=0.
- WATER, exit conditions evaluated each edge in priority order:
  - (a) moisture[z] >= HIGH_TH: normal finish.
  - (b) Water_sensor == 00: abort, no fault.
  - (c) timer == MAX_ON: set Fault[z].
  - (d) otherwise: timer++ and stay.
  - On (a), (b) or (c): Sprinkler goes to 0 at that edge, the FSM enters COOLDOWN, and pointer becomes (z+1) mod NZONES.
  - Sprinkler is therefore high for at most MAX_ON cycles.
  - Wet and timeout on the same edge: wet wins, no fault.
- COOLDOWN:
  - Sprinkler=0 for exactly COOL cycles, then IDLE.
  - Inputs are ignored apart from Reset and Fault_clr.
- Fault_clr:
  - Clears Fault at its edge in any state.
  - If it coincides with a timeout, clear wins (Fault[z] ends at 0).
  - Faulted zones are skipped by IDLE until cleared.
- Moisture readings are unsigned; threshold compares are MW-bit. The timer is clog2(MAX_ON+1) bits and never wraps.
- Sprinkler is never more than one-hot. Pump and Sprinkler may be high simultaneously.

Decomposition:
- Package irrigation_pkg holds:
  - FSM state encoding: IDLE, WATER, COOLDOWN.
  - Tank-level constants: LVL_EMPTY=2'b00, LVL_LOW=2'b01, LVL_OK=2'b10, LVL_FULL=2'b11.
- One sub-module, tank_pump_ctrl: CLK, Reset and Water_sensor in, Pump out; implements the hysteresis.
- The round-robin eligible-zone finder stays inline as a function.

Test Plan:
All scenarios use NZONES=4, MW=8, LOW_TH=64, HIGH_TH=160, MAX_ON=16, COOL=4.
1. Reset: hold Reset for 2 edges with random inputs -> Pump=0, Sprinkler=0000, Fault=0000, Active_zone=0; first non-reset edge follows normal rules.
2. Single zone: zone2=32, others=200, tank=10 -> Sprinkler=0100 and Active_zone=2 after the next edge. Raise zone2 to 170 -> Sprinkler=0000 at the following edge, then 4 cooldown cycles, then IDLE with no restart.
3. Timeout: zone3=32 held, others=200 -> Sprinkler=1000 for exactly 16 cycles, then 0000 and Fault=1000. Zone3 is never re-selected until a Fault_clr pulse; after clear plus cooldown, zone3 waters again.
4. Round-robin: zones 0 and 1 both at 32, neither ever reaching HIGH_TH -> zone0 times out, then zone1 is selected after cooldown (not zone0); Fault ends 0011.
5. Tank and pump:
   - Level sequence 01, 10, 11 -> Pump reads 1, 1, 0.
   - Level 00 while zone0 is watering -> Sprinkler=0000 at that edge, Fault unchanged.
   - Level 00 with a dry zone in IDLE -> no valve opens.
6. Reset mid-WATER at timer=7 -> all outputs 0 after that edge; watering restarts from zone0 and a full 16-cycle budget applies.
